// File: rtl/polyphase_decim_mac_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// polyphase_decim_mac_if : vector-in / sample-out bus of the polyphase MAC
// Rev 1.0
// ---------------------------------------------------------------------------
interface polyphase_decim_mac_if #(
  parameter int DW = 11,
  parameter int CW = 12
);
  logic                 in_valid;
  logic signed [DW-1:0] in_ph [4];
  logic signed [CW-1:0] coef  [4];
  logic                 in_ready;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 sat;
  logic                 overrun;

  modport master (
    output in_valid, in_ph, coef,
    input  in_ready, out_valid, out_data, sat, overrun
  );

  modport slave (
    input  in_valid, in_ph, coef,
    output in_ready, out_valid, out_data, sat, overrun
  );
endinterface
`default_nettype wire

// File: rtl/polyphase_decim_mac.sv
`default_nettype none
// ---------------------------------------------------------------------------
// polyphase_decim_mac : 4-tap polyphase weighted sum, two products per cycle,
// rounded (POLY_ROUND_EN) or truncated, saturated to DW bits.  Rev 1.0
// ---------------------------------------------------------------------------
module polyphase_decim_mac #(
  parameter int DW    = 11,
  parameter int CW    = 12,
  parameter int CFRAC = 10,
  parameter int ACCW  = DW + CW + 2
) (
  input  wire logic             clk,
  input  wire logic             reset,
  polyphase_decim_mac_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, MAC0 = 2'd1, MAC1 = 2'd2, OUT = 2'd3} state_t;

  localparam logic signed [ACCW-1:0] c_max = ACCW'(2**(DW-1) - 1);
  localparam logic signed [ACCW-1:0] c_min = -c_max - 1;
`ifdef POLY_ROUND_EN
  localparam logic signed [ACCW-1:0] c_round = ACCW'(2**(CFRAC-1));
`else
  localparam logic signed [ACCW-1:0] c_round = '0;
`endif

  state_t                 r_state, w_state_nxt;
  logic signed [DW-1:0]   r_ph [4];
  logic signed [CW-1:0]   r_cf [4];
  logic signed [ACCW-1:0] r_acc;
  logic signed [DW-1:0]   r_out_data;
  logic                   r_out_valid, r_sat, r_overrun;

  logic                   w_accept;
  logic signed [ACCW-1:0] w_sum, w_shift;
  logic signed [DW-1:0]   w_res;
  logic                   w_clip;

  function automatic logic signed [ACCW-1:0] f_mul(input logic signed [DW-1:0] p,
                                                   input logic signed [CW-1:0] c);
    logic signed [ACCW-1:0] pe, ce;
    pe = $signed({{(ACCW-DW){p[DW-1]}}, p});
    ce = $signed({{(ACCW-CW){c[CW-1]}}, c});
    return pe * ce;
  endfunction

  assign bus.in_ready  = reset & ((r_state == IDLE) | (r_state == OUT));
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.sat       = r_sat;
  assign bus.overrun   = r_overrun;

  // Second half of the sum plus rounding offset, then arithmetic rescale.
  assign w_sum   = r_acc + f_mul(r_ph[2], r_cf[2]) + f_mul(r_ph[3], r_cf[3]) + c_round;
  assign w_shift = w_sum >>> CFRAC;

  always_comb begin
    w_res  = w_shift[DW-1:0];
    w_clip = 1'b0;
    if (w_shift > c_max) begin
      w_res  = c_max[DW-1:0];
      w_clip = 1'b1;
    end else if (w_shift < c_min) begin
      w_res  = c_min[DW-1:0];
      w_clip = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_accept ? MAC0 : IDLE;
      MAC0:    w_state_nxt = MAC1;
      MAC1:    w_state_nxt = OUT;
      OUT:     w_state_nxt = w_accept ? MAC0 : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_ph[i] <= '0;
        r_cf[i] <= '0;
      end
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // Latched copies isolate the in-flight result from later input changes.
      if (w_accept) begin
        for (int i = 0; i < 4; i++) begin
          r_ph[i] <= bus.in_ph[i];
          r_cf[i] <= bus.coef[i];
        end
      end
      if (r_state == MAC0)
        r_acc <= f_mul(r_ph[0], r_cf[0]) + f_mul(r_ph[1], r_cf[1]);
      if (r_state == MAC1)
        r_out_data <= w_res;
      r_out_valid <= (r_state == MAC1);
      r_sat       <= (r_state == MAC1) & w_clip;
      r_overrun   <= bus.in_valid & ((r_state == MAC0) | (r_state == MAC1));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_polyphase_decim_mac.sv
`default_nettype none
// Directed self-checking bench for polyphase_decim_mac; checks assume the
// build macro POLY_ROUND_EN matches between bench and design.
module tb_polyphase_decim_mac;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  polyphase_decim_mac_if #(.DW(11), .CW(12)) bus ();

  polyphase_decim_mac #(.DW(11), .CW(12), .CFRAC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_vec(input int p0, input int p1, input int p2, input int p3,
                         input int c0, input int c1, input int c2, input int c3);
    bus.in_ph[0] = 11'(p0); bus.in_ph[1] = 11'(p1);
    bus.in_ph[2] = 11'(p2); bus.in_ph[3] = 11'(p3);
    bus.coef[0]  = 12'(c0); bus.coef[1]  = 12'(c1);
    bus.coef[2]  = 12'(c2); bus.coef[3]  = 12'(c3);
  endtask

  // Accepts the vector currently on the bus from IDLE/OUT; returns in MAC0.
  task automatic send();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  // From MAC0: walk to OUT and check the result appears exactly there.
  task automatic expect_out(input string tag, input int data, input int s);
    chk({tag, "_v_mac0"}, bus.out_valid, 0);
    step();
    chk({tag, "_v_mac1"}, bus.out_valid, 0);
    step();
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_data"}, bus.out_data, data);
    chk({tag, "_sat"}, bus.sat, s);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    set_vec(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    step(); step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_sat", bus.sat, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);
    step();

    // Unity tap
    set_vec(100, -7, 5, 9, 1024, 0, 0, 0);
    send();
    chk("unity_ready_mac0", bus.in_ready, 0);
    expect_out("unity", 100, 0);
    step();
    chk("unity_pulse_end", bus.out_valid, 0);
    chk("unity_hold", bus.out_data, 100);

    // Saturation and the largest non-clipping value
    set_vec(1000, 1000, 1000, 1000, 1024, 1024, 1024, 1024);
    send(); expect_out("pos_sat", 1023, 1); step();
    set_vec(-1024, -1024, -1024, -1024, 1024, 1024, 1024, 1024);
    send(); expect_out("neg_sat", -1024, 1); step();
    set_vec(1023, 0, 0, 0, 1024, 0, 0, 0);
    send(); expect_out("max_edge", 1023, 0); step();

    // Rounding of +/-1.5
    set_vec(3, 0, 0, 0, 512, 0, 0, 0);
    send();
`ifdef POLY_ROUND_EN
    expect_out("round_pos", 2, 0);
`else
    expect_out("round_pos", 1, 0);
`endif
    step();
    set_vec(-3, 0, 0, 0, 512, 0, 0, 0);
    send();
`ifdef POLY_ROUND_EN
    expect_out("round_neg", -1, 0);
`else
    expect_out("round_neg", -2, 0);
`endif
    step();

    // Streaming: accept in OUT chains straight into MAC0
    for (int k = 1; k <= 10; k++) begin
      set_vec(4*k, 4*k, 4*k, 4*k, 256, 256, 256, 256);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      chk("stream_ovr_mac0", bus.overrun, 0);
      step();
      chk("stream_ovr_mac1", bus.overrun, 0);
      step();
      chk("stream_valid", bus.out_valid, 1);
      chk("stream_data", bus.out_data, 4*k);
      chk("stream_ready_out", bus.in_ready, 1);
    end
    step();
    chk("stream_idle_valid", bus.out_valid, 0);
    chk("stream_idle_ovr", bus.overrun, 0);

    // Overrun during MAC0; inputs also change under the in-flight vector
    set_vec(200, 0, 0, 0, 1024, 0, 0, 0);
    send();
    set_vec(300, 11, 22, 33, 1024, 512, 512, 512);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("ovr_pulse", bus.overrun, 1);
    chk("ovr_ready_mac1", bus.in_ready, 0);
    step();
    chk("ovr_pulse_end", bus.overrun, 0);
    chk("ovr_first_valid", bus.out_valid, 1);
    chk("ovr_first_data", bus.out_data, 200);
    set_vec(300, 0, 0, 0, 1024, 0, 0, 0);
    send();
    expect_out("ovr_resend", 300, 0);
    step();

    // Asynchronous reset during MAC1
    set_vec(50, 0, 0, 0, 1024, 0, 0, 0);
    send();
    step();
    reset = 1'b0;
    #1;
    chk("mrst_data", bus.out_data, 0);
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_ready", bus.in_ready, 0);
    step(); step();
    chk("mrst_hold_valid", bus.out_valid, 0);
    reset = 1'b1;
    #1;
    chk("mrst_rel_ready", bus.in_ready, 1);
    step();
    chk("mrst_no_pulse", bus.out_valid, 0);
    step();
    chk("mrst_no_pulse2", bus.out_valid, 0);
    set_vec(77, 0, 0, 0, 1024, 0, 0, 0);
    send();
    expect_out("mrst_fresh", 77, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
